// File: rtl/pb_event_scheduler.sv
// Turns debounced button levels into short/long press events, offered one at a time
// over valid/ready with round-robin fairness. Define PB_AUTOREPEAT_EN for held-button auto-repeat.
module pb_event_scheduler #(
  parameter int          N_BTN      = 4,
  parameter logic [15:0] HOLD_CYC   = 16'd50000,
  parameter logic [15:0] REPEAT_CYC = 16'd25000,
  localparam int         ID_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] pb_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_long,
  output logic [N_BTN-1:0] pending,
  output logic             overrun
);

`ifdef PB_AUTOREPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif
  localparam int SW = ID_W + 1;

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [N_BTN-1:0] pb_q, rise, long_hit, rpt_fire, set_l;
  logic [N_BTN-1:0] pend_s, pend_l, clr_s, clr_l, rpt_act;
  logic [15:0]      hold_cnt [N_BTN];
  logic [15:0]      rpt_cnt  [N_BTN];
  logic [ID_W-1:0]  ptr, sel_idx;
  logic [SW-1:0]    sum;
  logic             sel_found, sel_long, hs, lost;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_BTN - 1)) ? '0 : id + ID_W'(1);
  endfunction

  assign rise    = pb_state & ~pb_q;
  assign hs      = evt_valid & evt_ready;
  assign pending = pend_s | pend_l;
  assign set_l   = long_hit | rpt_fire;

  // Per-button qualification and flag-clear decode
  always_comb begin
    long_hit = '0;
    rpt_fire = '0;
    clr_s    = '0;
    clr_l    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      long_hit[i] = pb_state[i] && (hold_cnt[i] == HOLD_CYC - 16'd1);
      rpt_fire[i] = RPT_EN && pb_state[i] && rpt_act[i] &&
                    (rpt_cnt[i] == REPEAT_CYC - 16'd1);
      clr_s[i]    = hs && !evt_long && (evt_id == ID_W'(i));
      clr_l[i]    = hs &&  evt_long && (evt_id == ID_W'(i));
    end
  end

  // A set landing on a flag that is still owed (and not being served) loses an event
  assign lost = |((rise & pend_s & ~clr_s) | (set_l & pend_l & ~clr_l));

  // Stage p0 -> p1: edge detect, hold/repeat timers, pending flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_q    <= '0;
      pend_s  <= '0;
      pend_l  <= '0;
      rpt_act <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        hold_cnt[i] <= '0;
        rpt_cnt[i]  <= '0;
      end
    end else begin
      pb_q    <= pb_state;
      pend_s  <= rise  | (pend_s & ~clr_s);
      pend_l  <= set_l | (pend_l & ~clr_l);
      overrun <= lost;
      for (int i = 0; i < N_BTN; i++) begin
        hold_cnt[i] <= pb_state[i] ? sat_inc(hold_cnt[i]) : 16'd0;
        if (!RPT_EN || !pb_state[i]) begin
          rpt_act[i] <= 1'b0;
          rpt_cnt[i] <= '0;
        end else if (set_l[i]) begin
          rpt_act[i] <= 1'b1;
          rpt_cnt[i] <= '0;
        end else if (rpt_act[i]) begin
          rpt_cnt[i] <= sat_inc(rpt_cnt[i]);
        end
      end
    end
  end

  // Round-robin pick: lowest pending index at or after ptr; descending scan leaves the nearest
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_long  = 1'b0;
    sum       = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N_BTN)) sum = sum - SW'(N_BTN);
      if (pending[sum[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = sum[ID_W-1:0];
        sel_long  = !pend_s[sum[ID_W-1:0]];
      end
    end
  end

  // Stage p1 -> p2: offer FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = OFFER;
      OFFER:   if (evt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state == OFFER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_id   <= '0;
      evt_long <= 1'b0;
      ptr      <= '0;
    end else if (state == IDLE && sel_found) begin
      evt_id   <= sel_idx;
      evt_long <= sel_long;
    end else if (hs) begin
      ptr      <= next_ptr(evt_id);
    end
  end

endmodule

// File: tb/tb_pb_event_scheduler.sv
// Directed bench for pb_event_scheduler (N_BTN=4, HOLD_CYC=8, REPEAT_CYC=4).
module tb_pb_event_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pb_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_long;
  logic [3:0] pending;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int vld_cycles = 0;
  int ovr_cnt = 0;

  typedef struct { int id; int lng; int cyc; } ev_t;
  ev_t ev_q[$];

  always #5 clk = ~clk;

  pb_event_scheduler #(.N_BTN(4), .HOLD_CYC(16'd8), .REPEAT_CYC(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .pb_state(pb_state), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id), .evt_long(evt_long),
    .pending(pending), .overrun(overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake recorder; the stored cycle number is that of the accepting edge
  always @(negedge clk) begin
    if (evt_valid) vld_cycles <= vld_cycles + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (evt_valid && evt_ready) ev_q.push_back('{id: int'(evt_id), lng: int'(evt_long), cyc: cyc + 1});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pb_state = 4'b0101; evt_ready = 1'b1;
    step(3);
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
    n_vec++; if ({evt_id, evt_long} !== 3'b000) begin n_err++; $display("FAIL rst_id_long: got %b want 000", {evt_id, evt_long}); end
    n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL rst_pending: got %b want 0000", pending); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    pb_state = 4'b0000; rst_n = 1'b1;
    step(3);
    n_vec++; if ({evt_valid, pending} !== 5'b0) begin n_err++; $display("FAIL post_rst_idle: got %b want 00000", {evt_valid, pending}); end
  endtask

  task automatic test_short();
    int q0 = ev_q.size();
    int v0 = vld_cycles;
    evt_ready = 1'b1; pb_state = 4'b0100;
    step(1);
    n_vec++; if ({pending, evt_valid} !== 5'b01000) begin n_err++; $display("FAIL short_edge1: got %b want 01000", {pending, evt_valid}); end
    step(1);
    n_vec++; if ({evt_valid, evt_id, evt_long} !== 4'b1100) begin n_err++; $display("FAIL short_offer: got %b want 1100", {evt_valid, evt_id, evt_long}); end
    step(1);
    n_vec++; if ({evt_valid, pending} !== 5'b0) begin n_err++; $display("FAIL short_served: got %b want 00000", {evt_valid, pending}); end
    pb_state = 4'b0000;
    step(12);
    n_vec++; if (ev_q.size() - q0 != 1) begin n_err++; $display("FAIL short_count: got %0d want 1", ev_q.size() - q0); end
    if (ev_q.size() > q0) begin
      n_vec++; if (ev_q[q0].id != 2 || ev_q[q0].lng != 0) begin n_err++; $display("FAIL short_event: got id %0d long %0d want id 2 long 0", ev_q[q0].id, ev_q[q0].lng); end
    end
    n_vec++; if (vld_cycles - v0 != 1) begin n_err++; $display("FAIL short_valid_width: got %0d want 1", vld_cycles - v0); end
  endtask

  task automatic test_hold(input int btn);
    int exp_rel[5] = '{3, 10, 14, 18, 22};
    int exp_lng[5] = '{0, 1, 1, 1, 1};
    int q0 = ev_q.size();
    int c0, n_exp;
`ifdef PB_AUTOREPEAT_EN
    n_exp = 5;
`else
    n_exp = 2;
`endif
    evt_ready = 1'b1;
    c0 = cyc;
    pb_state = 4'b0001 << btn;
    step(20);
    pb_state = 4'b0000;
    step(8);
    n_vec++; if (ev_q.size() - q0 != n_exp) begin n_err++; $display("FAIL hold%0d_count: got %0d want %0d", btn, ev_q.size() - q0, n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      if (q0 + i < ev_q.size()) begin
        n_vec++;
        if (ev_q[q0+i].id != btn || ev_q[q0+i].lng != exp_lng[i] || ev_q[q0+i].cyc - c0 != exp_rel[i]) begin
          n_err++;
          $display("FAIL hold%0d_event%0d: got id %0d long %0d edge %0d want id %0d long %0d edge %0d",
                   btn, i, ev_q[q0+i].id, ev_q[q0+i].lng, ev_q[q0+i].cyc - c0, btn, exp_lng[i], exp_rel[i]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_id[9] = '{0, 1, 3, 0, 1, 3, 1, 3, 0};
    int q0 = ev_q.size();
    rst_n = 1'b0; evt_ready = 1'b0; pb_state = 4'b0000;
    step(1);
    rst_n = 1'b1;
    step(1);
    pb_state = 4'b1011;
    step(1);
    pb_state = 4'b0000;
    step(1);
    n_vec++; if ({pending, evt_valid, evt_id} !== 7'b1011_1_00) begin n_err++; $display("FAIL rr_first_offer: got %b want 1011100", {pending, evt_valid, evt_id}); end
    evt_ready = 1'b1;
    step(8);
    pb_state = 4'b1011;
    step(1);
    pb_state = 4'b0000;
    step(10);
    evt_ready = 1'b0; pb_state = 4'b0010;
    step(1);
    pb_state = 4'b0000;
    step(1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0; pb_state = 4'b1001;
    step(1);
    pb_state = 4'b0000;
    step(1);
    n_vec++; if ({evt_valid, evt_id} !== 3'b1_11) begin n_err++; $display("FAIL rr_wrap_offer: got %b want 111", {evt_valid, evt_id}); end
    evt_ready = 1'b1;
    step(6);
    n_vec++; if (ev_q.size() - q0 != 9) begin n_err++; $display("FAIL rr_count: got %0d want 9", ev_q.size() - q0); end
    for (int i = 0; i < 9; i++) begin
      if (q0 + i < ev_q.size()) begin
        n_vec++;
        if (ev_q[q0+i].id != exp_id[i] || ev_q[q0+i].lng != 0) begin
          n_err++; $display("FAIL rr_order%0d: got id %0d long %0d want id %0d long 0", i, ev_q[q0+i].id, ev_q[q0+i].lng, exp_id[i]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int q0 = ev_q.size();
    int o0 = ovr_cnt;
    evt_ready = 1'b0; pb_state = 4'b0001;
    step(1);
    pb_state = 4'b0000;
    step(1);
    pb_state = 4'b0001;
    step(1);
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    pb_state = 4'b0000;
    step(1);
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_end: got %b want 0", overrun); end
    n_vec++; if (pending !== 4'b0001) begin n_err++; $display("FAIL ovr_flag_kept: got %b want 0001", pending); end
    evt_ready = 1'b1;
    step(6);
    n_vec++; if (ovr_cnt - o0 != 1) begin n_err++; $display("FAIL ovr_width: got %0d want 1", ovr_cnt - o0); end
    n_vec++; if (ev_q.size() - q0 != 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", ev_q.size() - q0); end
    if (ev_q.size() > q0) begin
      n_vec++; if (ev_q[q0].id != 0 || ev_q[q0].lng != 0) begin n_err++; $display("FAIL ovr_event: got id %0d long %0d want id 0 long 0", ev_q[q0].id, ev_q[q0].lng); end
    end
  endtask

  task automatic test_reset_mid_offer();
    int q0;
    evt_ready = 1'b0; pb_state = 4'b0100;
    step(1);
    pb_state = 4'b0000;
    step(1);
    n_vec++; if ({evt_valid, evt_id} !== 3'b1_10) begin n_err++; $display("FAIL rmo_offer: got %b want 110", {evt_valid, evt_id}); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({evt_valid, evt_id, pending} !== 7'b0) begin n_err++; $display("FAIL rmo_async: got %b want 0000000", {evt_valid, evt_id, pending}); end
    step(1);
    rst_n = 1'b1; evt_ready = 1'b1;
    q0 = ev_q.size();
    step(8);
    n_vec++; if (ev_q.size() - q0 != 0) begin n_err++; $display("FAIL rmo_dropped: got %0d events want 0", ev_q.size() - q0); end
    evt_ready = 1'b0; pb_state = 4'b1001;
    step(1);
    pb_state = 4'b0000;
    step(1);
    n_vec++; if ({evt_valid, evt_id} !== 3'b1_00) begin n_err++; $display("FAIL rmo_ptr_reset: got %b want 100", {evt_valid, evt_id}); end
    evt_ready = 1'b1;
    step(6);
    rst_n = 1'b0; pb_state = 4'b1000;
    step(2);
    rst_n = 1'b1;
    q0 = ev_q.size();
    step(3);
    pb_state = 4'b0000;
    step(6);
    n_vec++; if (ev_q.size() - q0 != 1) begin n_err++; $display("FAIL held_thru_rst_count: got %0d want 1", ev_q.size() - q0); end
    if (ev_q.size() > q0) begin
      n_vec++; if (ev_q[q0].id != 3 || ev_q[q0].lng != 0) begin n_err++; $display("FAIL held_thru_rst_event: got id %0d long %0d want id 3 long 0", ev_q[q0].id, ev_q[q0].lng); end
    end
  endtask

  initial begin
    rst_n = 1'b0; pb_state = 4'b0000; evt_ready = 1'b0;
    test_reset();
    test_short();
    test_hold(1);
`ifdef PB_AUTOREPEAT_EN
    test_hold(3);
`endif
    test_round_robin();
    test_overrun();
    test_reset_mid_offer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
